instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Instruction fetch stage of the single-issue RV32 core; sits directly upstream of decode/immediate extraction.
//   Holds the PC, issues in-order requests to instruction memory and tags each request with its PC.
//   Buffers returned words in a small in-order queue and presents {instr, pc, pc+4} to decode with valid/ready.
//   A redirect from execute (branch/jump) flushes the queue and discards in-flight responses.
// PARAMETERS
//   WIDTH      32             data/address width
//   RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//   BUF_DEPTH  2              fetch-queue entries (2..8); caps outstanding + buffered instructions
// PORTS
//   clk             in   1      clock, all state updates on rising edge
//   rst_n           in   1      synchronous active-low reset
//   imem_req_valid  out  1      fetch request valid
//   imem_req_ready  in   1      memory accepts request this cycle
//   imem_addr       out  WIDTH  fetch address (word aligned)
//   imem_rsp_valid  in   1      response valid; in order, exactly one per accepted request, >=1 cycle later
//   imem_rsp_data   in   WIDTH  instruction word
//   redirect_valid  in   1      taken branch/jump from execute
//   redirect_pc     in   WIDTH  redirect target
//   dec_valid       out  1      head entry holds a fetched instruction
//   dec_ready       in   1      decode accepts head
//   dec_instr       out  WIDTH  instruction word to decode/immediate extraction
//   dec_pc          out  WIDTH  PC of dec_instr
//   dec_pc_plus4    out  WIDTH  dec_pc + 4, modulo 2^WIDTH
//   fetch_stall_cnt out  32     (FETCH_STALL_CNT_EN only) stall counter
// BEHAVIOUR
//   - Reset: pc=RESET_PC, queue empty, drop_cnt=0; imem_req_valid=0 in the reset cycle, dec_valid=0, dec_instr=32'h0000_0013 (NOP), dec_pc=0, dec_pc_plus4=0.
//   - Issue: imem_req_valid = (count < BUF_DEPTH) && !redirect_valid; imem_addr=pc. On req_valid&&req_ready: allocate tail entry {pc, filled=0}, pc<=pc+4 (wraps).
//   - Response: if drop_cnt>0, discard and decrement drop_cnt; else write data into oldest unfilled entry, set filled.
//   - Output registered from queue head: rsp in cycle N -> dec_valid earliest N+1. dec_valid = head.filled && !redirect_valid.
//   - Pop on dec_valid&&dec_ready. Outputs hold stable while dec_valid&&!dec_ready.
//   - Redirect (highest priority): pc<=redirect_pc & ~3 (bits [1:0] forced 0), all entries cleared, drop_cnt<=drop_cnt + number of unfilled entries;
//     no issue, no pop and no fill in that cycle; a response arriving that cycle counts as dropped.
//   - Simultaneous fill+pop+issue: all allowed in one cycle; a full queue with pop issues next cycle (no same-cycle bypass).
//   - Full: count==BUF_DEPTH -> req_valid=0. Empty: dec_valid=0.
//   - Response with no unfilled entry and drop_cnt==0 is illegal; SVA assertion flags it.
//   - Reset mid-operation clears all state; instruction memory is reset on the same rst_n and returns no stale responses.
// CONFIGURATION
//   FETCH_STALL_CNT_EN defined: fetch_stall_cnt increments (saturating at 2^32-1) each cycle with !dec_valid && !redirect_valid; reset to 0.
//   Undefined: port and counter absent; no logic.
// STRUCTURE
//   cpu_pkg: RV_NOP = 32'h0000_0013, DEF_RESET_PC, typedef fetch_entry_t {pc, instr, filled}.
//   Sub-module fetch_queue: circular buffer with head/tail/fill pointers, count, flush; instr_fetch holds pc, drop_cnt, issue logic.
// TESTING
//   1. Reset, req_ready=1, 1-cycle memory -> addrs 0,4,8...; first dec_valid 2 cycles after first accept, dec_pc=0, dec_pc_plus4=4.
//   2. dec_ready=0 for 10 cycles -> exactly BUF_DEPTH requests accepted, then req_valid=0; outputs stable; release -> in-order 0,4.
//   3. Redirect to 32'h0000_0103 with 2 in flight -> next addr 0x100; both stale responses dropped; first dec_pc=0x100.
//   4. PC=32'hFFFF_FFFC -> dec_pc_plus4=0, next fetch addr 0x0.
//   5. rst_n low mid-stream with full queue -> next cycle dec_valid=0, dec_instr=0x13; then fetch restarts at RESET_PC.
//   6. FETCH_STALL_CNT_EN: 3-cycle memory latency, dec_ready=1 -> counter +3 at start-up; absent in build without macro.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core types and constants for the RV32 front end.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RV_NOP       = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries allocated at issue, filled by responses, popped by decode.
// Head visible the cycle after fill; flush clears every entry at once.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int BUF_DEPTH = 2,
  localparam int PTR_W     = $clog2(BUF_DEPTH),
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_alloc,
  input  logic [XLEN-1:0]  i_alloc_pc,
  input  logic             i_fill,
  input  logic [XLEN-1:0]  i_fill_instr,
  input  logic             i_pop,
  output logic             o_head_vld,
  output logic [XLEN-1:0]  o_head_pc,
  output logic [XLEN-1:0]  o_head_instr,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_unfilled
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  fetch_entry_t     r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_fill;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_unfilled;
  fetch_entry_t     w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Fill always lands on the oldest unfilled entry, so it never collides with a popped head.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_alloc) begin
        r_mem[r_tail].pc     <= i_alloc_pc;
        r_mem[r_tail].instr  <= RV_NOP;
        r_mem[r_tail].filled <= 1'b0;
        r_tail               <= ptr_inc(r_tail);
      end
      if (i_fill) begin
        r_mem[r_fill].instr  <= i_fill_instr;
        r_mem[r_fill].filled <= 1'b1;
        r_fill               <= ptr_inc(r_fill);
      end
      if (i_pop) begin
        r_mem[r_head].filled <= 1'b0;
        r_head               <= ptr_inc(r_head);
      end
      r_count    <= r_count + CNT_W'(i_alloc) - CNT_W'(i_pop);
      r_unfilled <= r_unfilled + CNT_W'(i_alloc) - CNT_W'(i_fill);
    end
  end

  assign w_head       = r_mem[r_head];
  assign o_head_vld   = (r_count != '0) && w_head.filled;
  assign o_head_pc    = w_head.pc;
  assign o_head_instr = w_head.instr;
  assign o_count      = r_count;
  assign o_unfilled   = r_unfilled;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, in-order imem requests, drop of stale responses after redirect. Decode sees a fill
// one cycle later; issue stops when the queue is full. Optional stall counter under FETCH_STALL_CNT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = DEF_RESET_PC,
  parameter int               BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [WIDTH-1:0] dec_instr,
  output logic [WIDTH-1:0] dec_pc,
  output logic [WIDTH-1:0] dec_pc_plus4
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]      fetch_stall_cnt
`endif
);

  localparam int               CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int               DROP_W  = 8;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [WIDTH-1:0]  r_pc;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_alloc;
  logic              w_fill;
  logic              w_pop;
  logic              w_head_vld;
  logic [WIDTH-1:0]  w_head_pc;
  logic [WIDTH-1:0]  w_head_instr;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_unfilled;

  assign imem_req_valid = rst_n && (w_count < DEPTH_C) && !redirect_valid;
  assign imem_addr      = r_pc;
  assign w_alloc        = imem_req_valid && imem_req_ready;
  assign w_fill         = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);
  assign dec_valid      = w_head_vld && !redirect_valid;
  assign w_pop          = dec_valid && dec_ready;

  fetch_queue #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (redirect_valid),
    .i_alloc      (w_alloc),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_fill),
    .i_fill_instr (imem_rsp_data),
    .i_pop        (w_pop),
    .o_head_vld   (w_head_vld),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr),
    .o_count      (w_count),
    .o_unfilled   (w_unfilled)
  );

  // A response in the redirect cycle retires either a pending drop or the oldest unfilled entry,
  // so it is subtracted from the new total either way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc & ~WIDTH'(3);
      r_drop_cnt <= r_drop_cnt + DROP_W'(w_unfilled) - DROP_W'(imem_rsp_valid);
    end else begin
      if (w_alloc) begin
        r_pc <= r_pc + WIDTH'(4);
      end
      if (imem_rsp_valid && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  assign dec_instr    = w_head_vld ? w_head_instr : RV_NOP;
  assign dec_pc       = w_head_vld ? w_head_pc : '0;
  assign dec_pc_plus4 = w_head_vld ? (w_head_pc + WIDTH'(4)) : '0;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!dec_valid && !redirect_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign fetch_stall_cnt = r_stall_cnt;
`endif

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> ((r_drop_cnt != '0) || (w_unfilled != '0)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order instruction memory model of programmable latency.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  instr_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
`ifdef FETCH_STALL_CNT_EN
    .fetch_stall_cnt (stall_cnt),
`endif
    .dec_pc_plus4    (dec_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: request accepted in cycle k answers in cycle k+mem_lat, in order.
  int          cyc     = 0;
  int          mem_lat = 1;
  logic [31:0] pq_addr[$];
  int          pq_due[$];

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_req_valid && imem_req_ready) begin
      pq_addr.push_back(imem_addr);
      pq_due.push_back(cyc + mem_lat);
    end
  end

  always @(posedge clk) begin
    #2;
    cyc            = cyc + 1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst_n !== 1'b1) begin
      pq_addr.delete();
      pq_due.delete();
    end else if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pq_addr[0]);
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit chk_state);
    rst_n          = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    next();
    next();
    @(negedge clk);
    if (chk_state) begin
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_dec_valid", 32'(dec_valid), 0);
      chk("rst_dec_instr", dec_instr, 32'h0000_0013);
      chk("rst_dec_pc", dec_pc, 0);
      chk("rst_dec_pc_plus4", dec_pc_plus4, 0);
`ifdef FETCH_STALL_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
    end
    next();
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_dv;
    logic [31:0] exp_dpc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic exp_rv, input logic [31:0] exp_addr,
                     input logic exp_dv, input logic [31:0] exp_dpc);
    vec_t v;
    v.rdy      = rdy;
    v.redir    = redir;
    v.rpc      = rpc;
    v.exp_rv   = exp_rv;
    v.exp_addr = exp_addr;
    v.exp_dv   = exp_dv;
    v.exp_dpc  = exp_dpc;
    vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  acc;
    bit  found;
    // Cycle-by-cycle stream with 1-cycle memory, BUF_DEPTH=2: steady state, backpressure, redirect.
    add(1, 0, 0,          1, 32'h0,   0, 0);
    add(1, 0, 0,          1, 32'h4,   0, 0);
    add(1, 0, 0,          0, 0,       1, 32'h0);
    add(1, 0, 0,          1, 32'h8,   1, 32'h4);
    add(1, 0, 0,          1, 32'hC,   0, 0);
    add(1, 0, 0,          0, 0,       1, 32'h8);
    add(1, 0, 0,          1, 32'h10,  1, 32'hC);
    add(0, 0, 0,          1, 32'h14,  0, 0);
    for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 0, 1, 32'h10);
    add(1, 0, 0,          0, 0,       1, 32'h10);
    add(1, 0, 0,          1, 32'h18,  1, 32'h14);
    add(1, 0, 0,          1, 32'h1C,  0, 0);
    add(1, 1, 32'h203,    0, 0,       0, 0);
    add(1, 0, 0,          1, 32'h200, 0, 0);
    add(1, 0, 0,          1, 32'h204, 0, 0);
    add(1, 0, 0,          0, 0,       1, 32'h200);
    add(1, 0, 0,          1, 32'h208, 1, 32'h204);

    do_reset(1);
    mem_lat = 1;
    for (int i = 0; i < vq.size(); i++) begin
      dec_ready      = vq[i].rdy;
      redirect_valid = vq[i].redir;
      redirect_pc    = vq[i].rpc;
      @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vq[i].exp_rv));
      if (vq[i].exp_rv) chk($sformatf("vec%0d_addr", i), imem_addr, vq[i].exp_addr);
      chk($sformatf("vec%0d_dec_valid", i), 32'(dec_valid), 32'(vq[i].exp_dv));
      if (vq[i].exp_dv) begin
        chk($sformatf("vec%0d_dec_pc", i), dec_pc, vq[i].exp_dpc);
        chk($sformatf("vec%0d_dec_pc_plus4", i), dec_pc_plus4, vq[i].exp_dpc + 32'd4);
        chk($sformatf("vec%0d_dec_instr", i), dec_instr, word(vq[i].exp_dpc));
      end
      next();
    end
    redirect_valid = 1'b0;

    // Decode stalled for 10 cycles: only BUF_DEPTH requests go out, head holds.
    do_reset(0);
    mem_lat   = 1;
    dec_ready = 1'b0;
    acc       = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) acc++;
      if (i == 9) begin
        chk("stall_req_valid", 32'(imem_req_valid), 0);
        chk("stall_dec_valid", 32'(dec_valid), 1);
        chk("stall_dec_pc", dec_pc, 32'h0);
        chk("stall_dec_instr", dec_instr, word(32'h0));
      end
      next();
    end
    chk("stall_accepts", 32'(acc), 2);
    dec_ready = 1'b1;
    @(negedge clk);
    chk("release0_dec_valid", 32'(dec_valid), 1);
    chk("release0_dec_pc", dec_pc, 32'h0);
    next();
    @(negedge clk);
    chk("release1_dec_valid", 32'(dec_valid), 1);
    chk("release1_dec_pc", dec_pc, 32'h4);
    next();

    // Redirect with two responses in flight (3-cycle memory).
    do_reset(0);
    mem_lat   = 3;
    dec_ready = 1'b1;
    @(negedge clk);
    chk("redir_first_addr", imem_addr, 32'h0);
    next();
    next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    chk("redir_cycle_req_valid", 32'(imem_req_valid), 0);
    chk("redir_cycle_dec_valid", 32'(dec_valid), 0);
    next();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_req_valid", 32'(imem_req_valid), 1);
    chk("redir_addr", imem_addr, 32'h100);
    next();
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (dec_valid) begin
        found = 1'b1;
        chk("redir_dec_pc", dec_pc, 32'h100);
        chk("redir_dec_instr", dec_instr, word(32'h100));
        chk("redir_dec_pc_plus4", dec_pc_plus4, 32'h104);
      end
      next();
    end
    if (!found) chk("redir_dec_valid_timeout", 0, 1);

    // PC wrap at the top of the address space.
    do_reset(0);
    mem_lat        = 1;
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_redir_req_valid", 32'(imem_req_valid), 0);
    next();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    next();
    @(negedge clk);
    chk("wrap_req_valid1", 32'(imem_req_valid), 1);
    chk("wrap_addr1", imem_addr, 32'h0);
    next();
    @(negedge clk);
    chk("wrap_dec_valid", 32'(dec_valid), 1);
    chk("wrap_dec_pc", dec_pc, 32'hFFFF_FFFC);
    chk("wrap_dec_pc_plus4", dec_pc_plus4, 32'h0);

    // Reset mid-stream with a full queue.
    next();
    do_reset(0);
    mem_lat   = 1;
    dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) next();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_valid", 32'(imem_req_valid), 0);
    next();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_dec_valid", 32'(dec_valid), 0);
    chk("midrst_dec_instr", dec_instr, 32'h0000_0013);
    chk("midrst_dec_pc", dec_pc, 32'h0);
    chk("midrst_req_valid_after", 32'(imem_req_valid), 1);
    chk("midrst_addr_after", imem_addr, 32'h0);
    dec_ready = 1'b1;
    next();
    next();
    @(negedge clk);
    chk("midrst_restart_dec_valid", 32'(dec_valid), 1);
    chk("midrst_restart_dec_pc", dec_pc, 32'h0);
    next();

`ifdef FETCH_STALL_CNT_EN
    // 3-cycle memory: three extra stall cycles after the first issue cycle.
    begin
      logic [31:0] c1;
      do_reset(1);
      mem_lat   = 3;
      dec_ready = 1'b1;
      next();
      @(negedge clk);
      c1 = stall_cnt;
      next();
      next();
      next();
      @(negedge clk);
      chk("stallcnt_dec_valid", 32'(dec_valid), 1);
      chk("stallcnt_delta", stall_cnt - c1, 32'd3);
      next();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
